// File: rtl/mul_share_arbiter.sv
// Round-robin front end for one shared, non-stallable 64x64 pipelined multiplier.
// Grants one operand pair per cycle, tracks each op with a valid/ID tag pipe matched
// to the multiplier latency, and returns the 128-bit product to its requester.
// Optional perf counters are built when MUL_ARB_PERF_EN is defined.
module mul_share_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned IDW     = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 en,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*64-1:0]   req_x,
    input  logic [NREQ*64-1:0]   req_y,
    output logic [63:0]          mul_x,
    output logic [63:0]          mul_y,
    input  logic [127:0]         mul_p,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [127:0]         rsp_p,
    output logic                 idle,
    output logic [31:0]          perf_issue,
    output logic [31:0]          perf_conflict
);

    logic [IDW-1:0] ptr_q;
    logic [MUL_LAT:0] tag_v_q;
    logic [IDW-1:0] tag_id_q [MUL_LAT+1];

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic            hs;
    logic [IDW-1:0]  sel;

    // Round-robin search starting just above the last granted requester.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        hs       = 1'b0;
        sel      = '0;
        if (reset && en) begin
            for (int k = 1; k <= int'(NREQ); k++) begin
                sel = IDW'((int'(ptr_q) + k) % int'(NREQ));
                if (!hs && req_valid[sel]) begin
                    hs         = 1'b1;
                    grant[sel] = 1'b1;
                    grant_id   = sel;
                end
            end
        end
    end

    assign req_ready = grant;

    // Issue operands, advance the tag pipe, and register the returning product.
    always_ff @(posedge clock) begin
        if (!reset) begin
            ptr_q     <= IDW'(NREQ - 1);
            tag_v_q   <= '0;
            for (int k = 0; k <= int'(MUL_LAT); k++) begin
                tag_id_q[k] <= '0;
            end
            mul_x     <= '0;
            mul_y     <= '0;
            rsp_valid <= '0;
            rsp_id    <= '0;
            rsp_p     <= '0;
        end else begin
            if (hs) begin
                ptr_q <= grant_id;
                mul_x <= req_x[64*int'(grant_id) +: 64];
                mul_y <= req_y[64*int'(grant_id) +: 64];
            end
            tag_v_q     <= {tag_v_q[MUL_LAT-1:0], hs};
            tag_id_q[0] <= grant_id;
            for (int k = 1; k <= int'(MUL_LAT); k++) begin
                tag_id_q[k] <= tag_id_q[k-1];
            end
            // Final tag stage lines up with mul_p carrying that op's product.
            if (tag_v_q[MUL_LAT]) begin
                rsp_valid <= NREQ'(1) << tag_id_q[MUL_LAT];
                rsp_id    <= tag_id_q[MUL_LAT];
                rsp_p     <= mul_p;
            end else begin
                rsp_valid <= '0;
            end
        end
    end

    assign idle = ~(|tag_v_q) & ~(|rsp_valid);

`ifdef MUL_ARB_PERF_EN
    logic [31:0] issue_q;
    logic [31:0] conflict_q;
    logic        multi_req;

    // Two or more requesters contending in one cycle.
    assign multi_req = (req_valid & (req_valid - NREQ'(1))) != '0;

    // Saturating perf counters.
    always_ff @(posedge clock) begin
        if (!reset) begin
            issue_q    <= '0;
            conflict_q <= '0;
        end else begin
            if (hs && issue_q != 32'hFFFF_FFFF) begin
                issue_q <= issue_q + 32'd1;
            end
            if (en && multi_req && conflict_q != 32'hFFFF_FFFF) begin
                conflict_q <= conflict_q + 32'd1;
            end
        end
    end

    assign perf_issue    = issue_q;
    assign perf_conflict = conflict_q;
`else
    assign perf_issue    = '0;
    assign perf_conflict = '0;
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with a behavioural pipelined multiplier.
// Perf expectations follow MUL_ARB_PERF_EN.
`timescale 1ns/1ps
module tb_mul_share_arbiter;

    localparam int NREQ    = 4;
    localparam int MUL_LAT = 4;
    localparam int IDW     = 2;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic                en = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*64-1:0]  req_x = '0;
    logic [NREQ*64-1:0]  req_y = '0;
    logic [63:0]         mul_x;
    logic [63:0]         mul_y;
    logic [127:0]        mul_p;
    logic [NREQ-1:0]     rsp_valid;
    logic [IDW-1:0]      rsp_id;
    logic [127:0]        rsp_p;
    logic                idle;
    logic [31:0]         perf_issue;
    logic [31:0]         perf_conflict;

    mul_share_arbiter #(.NREQ(NREQ), .MUL_LAT(MUL_LAT), .IDW(IDW)) dut (
        .clock(clock), .reset(reset), .en(en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y),
        .mul_x(mul_x), .mul_y(mul_y), .mul_p(mul_p),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_p(rsp_p),
        .idle(idle), .perf_issue(perf_issue), .perf_conflict(perf_conflict)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Multiplier model: product valid MUL_LAT edges after operands appear; never reset.
    logic [127:0] mp [MUL_LAT];
    always @(posedge clock) begin
        mp[0] <= {64'd0, mul_x} * {64'd0, mul_y};
        for (int k = 1; k < MUL_LAT; k++) mp[k] <= mp[k-1];
    end
    assign mul_p = mp[MUL_LAT-1];

    typedef struct {
        logic [NREQ-1:0] v;
        logic [IDW-1:0]  id;
        logic [127:0]    p;
        logic            idl;
        int              c;
    } rsp_rec_t;
    rsp_rec_t rq[$];

    // Response collector.
    always @(negedge clock) begin
        if (rsp_valid != '0) rq.push_back('{rsp_valid, rsp_id, rsp_p, idle, cyc});
    end

    typedef struct {
        logic            en;
        logic [NREQ-1:0] rv;
        logic [NREQ-1:0] exp;
    } gvec_t;
    gvec_t gtab [7];

    int checks = 0;
    int errors = 0;
    int hs_c;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [63:0] x, input logic [63:0] y);
        req_x[64*i +: 64] = x;
        req_y[64*i +: 64] = y;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        req_valid = '0;
        en = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        rq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Grant vectors applied right after reset, pointer = NREQ-1.
        gtab[0] = '{1'b1, 4'b0000, 4'b0000};
        gtab[1] = '{1'b1, 4'b1111, 4'b0001};
        gtab[2] = '{1'b1, 4'b1010, 4'b0010};
        gtab[3] = '{1'b1, 4'b1000, 4'b1000};
        gtab[4] = '{1'b0, 4'b1111, 4'b0000};
        gtab[5] = '{1'b1, 4'b0110, 4'b0010};
        gtab[6] = '{1'b1, 4'b1001, 4'b0001};

        do_reset();
        chk("rst_rsp_valid", 128'(rsp_valid), 128'd0);
        chk("rst_rsp_id", 128'(rsp_id), 128'd0);
        chk("rst_rsp_p", rsp_p, 128'd0);
        chk("rst_mul_x", 128'(mul_x), 128'd0);
        chk("rst_mul_y", 128'(mul_y), 128'd0);
        chk("rst_idle", 128'(idle), 128'd1);
        chk("rst_perf_issue", 128'(perf_issue), 128'd0);
        chk("rst_perf_conflict", 128'(perf_conflict), 128'd0);

        // Combinational grant table; valid dropped before the edge so no handshake.
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            en = gtab[i].en;
            req_valid = gtab[i].rv;
            #1;
            chk($sformatf("grant_tab%0d", i), 128'(req_ready), 128'(gtab[i].exp));
            req_valid = '0;
            en = 1'b1;
        end

        // Single op from requester 2, all-ones squared.
        @(negedge clock);
        set_op(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        req_valid = 4'b0100;
        #1;
        chk("single_ready", 128'(req_ready), 128'(4'b0100));
        hs_c = cyc;
        @(negedge clock);
        req_valid = '0;
        repeat (10) @(negedge clock);
        chk("single_count", 128'(rq.size()), 128'd1);
        if (rq.size() == 1) begin
            chk("single_valid", 128'(rq[0].v), 128'(4'b0100));
            chk("single_id", 128'(rq[0].id), 128'd2);
            chk("single_p", rq[0].p, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
            chk("single_latency", 128'(rq[0].c - hs_c), 128'(MUL_LAT + 2));
            chk("single_idle_during", 128'(rq[0].idl), 128'd0);
        end
        chk("single_idle_after", 128'(idle), 128'd1);

        // Four-way contention: strict rotation, gap-free responses.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, 64'(i + 1), 64'h10);
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            req_valid = 4'b1111;
            #1;
            chk($sformatf("rr_grant%0d", k), 128'(req_ready), 128'(4'b0001 << (k % 4)));
        end
        @(negedge clock);
        req_valid = '0;
        repeat (12) @(negedge clock);
        chk("rr_count", 128'(rq.size()), 128'd8);
        if (rq.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                chk($sformatf("rr_id%0d", k), 128'(rq[k].id), 128'(k % 4));
                chk($sformatf("rr_v%0d", k), 128'(rq[k].v), 128'(4'b0001 << (k % 4)));
                chk($sformatf("rr_p%0d", k), rq[k].p, 128'(((k % 4) + 1) * 16));
                chk($sformatf("rr_cyc%0d", k), 128'(rq[k].c - rq[0].c), 128'(k));
            end
        end

        // Requester 1 streaming alone.
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            set_op(1, 64'(k), 64'(k));
            req_valid = 4'b0010;
            #1;
            chk($sformatf("stream_ready%0d", k), 128'(req_ready), 128'(4'b0010));
        end
        @(negedge clock);
        req_valid = '0;
        repeat (12) @(negedge clock);
        chk("stream_count", 128'(rq.size()), 128'd8);
        if (rq.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                chk($sformatf("stream_p%0d", k), rq[k].p, 128'((k + 1) * (k + 1)));
                chk($sformatf("stream_cyc%0d", k), 128'(rq[k].c - rq[0].c), 128'(k));
            end
        end

        // Three grants then en dropped with the request still held.
        do_reset();
        set_op(0, 64'd3, 64'd5);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            req_valid = 4'b0001;
            #1;
            chk($sformatf("en_grant%0d", k), 128'(req_ready), 128'(4'b0001));
            hs_c = cyc;
        end
        @(negedge clock);
        en = 1'b0;
        #1;
        chk("en_off_ready", 128'(req_ready), 128'd0);
        while (cyc < hs_c + MUL_LAT + 3) @(negedge clock);
        chk("en_idle_after_last", 128'(idle), 128'd1);
        chk("en_off_ready_late", 128'(req_ready), 128'd0);
        repeat (6) @(negedge clock);
        chk("en_count", 128'(rq.size()), 128'd3);
        if (rq.size() == 3) begin
            chk("en_last_latency", 128'(rq[2].c - hs_c), 128'(MUL_LAT + 2));
            chk("en_last_idle", 128'(rq[2].idl), 128'd0);
            chk("en_last_p", rq[2].p, 128'd15);
        end
        req_valid = '0;
        en = 1'b1;

        // Reset two cycles after a grant discards the op.
        do_reset();
        set_op(1, 64'd9, 64'd9);
        set_op(0, 64'd5, 64'd7);
        set_op(3, 64'd2, 64'd2);
        @(negedge clock);
        req_valid = 4'b0010;
        #1;
        chk("mid_rst_grant", 128'(req_ready), 128'(4'b0010));
        @(negedge clock);
        req_valid = '0;
        @(negedge clock);
        reset = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("in_rst_ready", 128'(req_ready), 128'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        req_valid = 4'b1001;
        #1;
        chk("post_rst_idle", 128'(idle), 128'd1);
        chk("post_rst_tie", 128'(req_ready), 128'(4'b0001));
        @(negedge clock);
        req_valid = '0;
        repeat (12) @(negedge clock);
        chk("mid_rst_count", 128'(rq.size()), 128'd1);
        if (rq.size() == 1) begin
            chk("mid_rst_id", 128'(rq[0].id), 128'd0);
            chk("mid_rst_p", rq[0].p, 128'd35);
        end

        // Ten cycles of two-way contention for the perf counters.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            req_valid = 4'b0011;
        end
        @(negedge clock);
        req_valid = '0;
        #1;
`ifdef MUL_ARB_PERF_EN
        chk("perf_issue", 128'(perf_issue), 128'd10);
        chk("perf_conflict", 128'(perf_conflict), 128'd10);
`else
        chk("perf_issue", 128'(perf_issue), 128'd0);
        chk("perf_conflict", 128'(perf_conflict), 128'd0);
`endif
        repeat (10) @(negedge clock);
        chk("perf_rsp_count", 128'(rq.size()), 128'd10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
